// File: rtl/alu_req_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_driver_if
// Brief    : Request, ALU-pin and response bundle for alu_req_driver.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_req_driver_if #(
  parameter int OP_W  = 8,
  parameter int RES_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_a;
  logic [OP_W-1:0]  req_b;
  logic [2:0]       req_opcode;
  logic [OP_W-1:0]  req_tag;

  logic [OP_W-1:0]  alu_a;
  logic [OP_W-1:0]  alu_b;
  logic [2:0]       alu_opcode;
  logic [OP_W-1:0]  alu_addr;
  logic [RES_W-1:0] alu_result;
  logic [OP_W-1:0]  alu_addr_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_result;
  logic [OP_W-1:0]  rsp_tag;
  logic             rsp_err;

  // Driver side
  modport master (
    input  req_valid, req_a, req_b, req_opcode, req_tag,
    input  alu_result, alu_addr_out, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode, alu_addr,
    output rsp_valid, rsp_result, rsp_tag, rsp_err
  );

  // Stimulus source / ALU / response sink side
  modport slave (
    output req_valid, req_a, req_b, req_opcode, req_tag,
    output alu_result, alu_addr_out, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode, alu_addr,
    input  rsp_valid, rsp_result, rsp_tag, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_req_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_driver
// Brief    : Issues tagged requests to a 1-cycle-latency ALU and returns
//            in-order tagged responses through a small response FIFO.
// Options  : ALU_REQ_DRIVER_CHECK_EN adds chk_error / chk_count result check.
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_driver #(
  parameter int OP_W      = 8,
  parameter int RES_W     = 16,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_req_driver_if.master bus
`ifdef ALU_REQ_DRIVER_CHECK_EN
  ,
  output logic             chk_error,
  output logic [15:0]      chk_count
`endif
);

  localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_OCC_W = c_CNT_W + 1;

  localparam logic [2:0] c_OP_PASSA = 3'd2;
  localparam logic [2:0] c_OP_NEGA  = 3'd4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             rdy_en_q,   rdy_en_d;

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_tag_q,   s1_tag_d;
  logic             s1_err_q,   s1_err_d;

  logic [OP_W-1:0]  alu_a_q,    alu_a_d;
  logic [OP_W-1:0]  alu_b_q,    alu_b_d;
  logic [2:0]       alu_op_q,   alu_op_d;
  logic [OP_W-1:0]  alu_addr_q, alu_addr_d;

  logic             s2_valid_q, s2_valid_d;
  logic [OP_W-1:0]  s2_tag_q,   s2_tag_d;
  logic             s2_err_q,   s2_err_d;

  logic [RES_W-1:0] fifo_res_q [RSP_DEPTH];
  logic [RES_W-1:0] fifo_res_d [RSP_DEPTH];
  logic [OP_W-1:0]  fifo_tag_q [RSP_DEPTH];
  logic [OP_W-1:0]  fifo_tag_d [RSP_DEPTH];
  logic             fifo_err_q [RSP_DEPTH];
  logic             fifo_err_d [RSP_DEPTH];

  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q,  count_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic [c_OCC_W-1:0] w_occ;
  logic               w_req_ready;
  logic               w_accept;
  logic               w_illegal;
  logic               w_push;
  logic               w_pop;
  logic               w_rsp_valid;

  // Occupancy reserves a FIFO slot for every op still in the pipeline.
  assign w_occ       = c_OCC_W'(count_q) + c_OCC_W'(s1_valid_q) + c_OCC_W'(s2_valid_q);
  assign w_req_ready = reset_n && rdy_en_q && (w_occ < c_OCC_W'(RSP_DEPTH));
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_illegal   = (bus.req_opcode > c_OP_NEGA);
  assign w_rsp_valid = (count_q != '0);
  assign w_push      = s2_valid_q;
  assign w_pop       = w_rsp_valid && bus.rsp_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rdy_en_d   = 1'b1;

    s1_valid_d = w_accept;
    s1_tag_d   = bus.req_tag;
    s1_err_d   = w_illegal;

    // Idle pattern unless a legal op is being issued this cycle.
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_op_d   = c_OP_PASSA;
    alu_addr_d = '0;
    if (w_accept && !w_illegal) begin
      alu_a_d    = bus.req_a;
      alu_b_d    = bus.req_b;
      alu_op_d   = bus.req_opcode;
      alu_addr_d = bus.req_tag;
    end

    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
    s2_err_d   = s1_err_q || (bus.alu_addr_out != alu_addr_q);

    fifo_res_d = fifo_res_q;
    fifo_tag_d = fifo_tag_q;
    fifo_err_d = fifo_err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (w_push) begin
      fifo_res_d[wr_ptr_q] = s2_err_q ? '0 : bus.alu_result;
      fifo_tag_d[wr_ptr_q] = s2_tag_q;
      fifo_err_d[wr_ptr_q] = s2_err_q;
      wr_ptr_d             = wr_ptr_q + c_PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
    end
    if (w_push && !w_pop) begin
      count_d = count_q + c_CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_err_q   <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= c_OP_PASSA;
      alu_addr_q <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_err_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s1_err_q   <= s1_err_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      alu_addr_q <= alu_addr_d;
      s2_valid_q <= s2_valid_d;
      s2_tag_q   <= s2_tag_d;
      s2_err_q   <= s2_err_d;
      fifo_res_q <= fifo_res_d;
      fifo_tag_q <= fifo_tag_d;
      fifo_err_q <= fifo_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready  = w_req_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_addr   = alu_addr_q;

  // Head is masked when empty so stale storage never appears on the bus.
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = w_rsp_valid ? fifo_res_q[rd_ptr_q] : '0;
  assign bus.rsp_tag    = w_rsp_valid ? fifo_tag_q[rd_ptr_q] : '0;
  assign bus.rsp_err    = w_rsp_valid ? fifo_err_q[rd_ptr_q] : 1'b0;

`ifdef ALU_REQ_DRIVER_CHECK_EN
  // ---------------------------------------------------------------------------
  // Result checker: independent expectation carried alongside each op
  // ---------------------------------------------------------------------------
  localparam logic [2:0] c_OP_ADD   = 3'd0;
  localparam logic [2:0] c_OP_SUB   = 3'd1;
  localparam logic [2:0] c_OP_PASSB = 3'd3;

  function automatic logic [RES_W-1:0] calc_expected(
    input logic [OP_W-1:0] a,
    input logic [OP_W-1:0] b,
    input logic [2:0]      op
  );
    logic [RES_W-1:0] ea;
    logic [RES_W-1:0] eb;
    ea = RES_W'(a);
    eb = RES_W'(b);
    case (op)
      c_OP_ADD:   calc_expected = ea + eb;
      c_OP_SUB:   calc_expected = ea - eb;
      c_OP_PASSA: calc_expected = ea;
      c_OP_PASSB: calc_expected = eb;
      c_OP_NEGA:  calc_expected = '0 - ea;
      default:    calc_expected = '0;
    endcase
  endfunction

  logic [RES_W-1:0] s1_exp_q,    s1_exp_d;
  logic [RES_W-1:0] s2_exp_q,    s2_exp_d;
  logic             s1_chk_q,    s1_chk_d;
  logic             s2_chk_q,    s2_chk_d;
  logic             chk_error_q, chk_error_d;
  logic [15:0]      chk_count_q, chk_count_d;

  always_comb begin
    s1_exp_d    = calc_expected(bus.req_a, bus.req_b, bus.req_opcode);
    s1_chk_d    = w_accept && !w_illegal;
    s2_exp_d    = s1_exp_q;
    s2_chk_d    = s1_chk_q;
    chk_error_d = chk_error_q;
    chk_count_d = chk_count_q;
    if (s2_valid_q && s2_chk_q && (bus.alu_result != s2_exp_q)) begin
      chk_error_d = 1'b1;
      if (chk_count_q != 16'hFFFF) begin
        chk_count_d = chk_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_exp_q    <= '0;
      s2_exp_q    <= '0;
      s1_chk_q    <= 1'b0;
      s2_chk_q    <= 1'b0;
      chk_error_q <= 1'b0;
      chk_count_q <= '0;
    end else begin
      s1_exp_q    <= s1_exp_d;
      s2_exp_q    <= s2_exp_d;
      s1_chk_q    <= s1_chk_d;
      s2_chk_q    <= s2_chk_d;
      chk_error_q <= chk_error_d;
      chk_count_q <= chk_count_d;
    end
  end

  assign chk_error = chk_error_q;
  assign chk_count = chk_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_req_driver.sv
`default_nettype none
// Testbench for alu_req_driver: directed scenarios plus a randomized run
// scored against a transaction-level model with a behavioural ALU.
module tb_alu_req_driver;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic bad_add = 1'b0;
  logic addr_corrupt = 1'b0;
  logic alu_saw_illegal = 1'b0;
  logic [RES_W-1:0] alu_res_q;

  always #5 clk = ~clk;

  alu_req_driver_if #(.OP_W(OP_W), .RES_W(RES_W)) bus ();

`ifdef ALU_REQ_DRIVER_CHECK_EN
  logic        chk_error;
  logic [15:0] chk_count;
`endif

  alu_req_driver #(.OP_W(OP_W), .RES_W(RES_W), .RSP_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ALU_REQ_DRIVER_CHECK_EN
    ,
    .chk_error (chk_error),
    .chk_count (chk_count)
`endif
  );

  // Behavioural ALU: registered result, combinational address echo.
  always @(posedge clk) begin
    case (bus.alu_opcode)
      3'd0: alu_res_q <= bad_add ? ({8'h00, bus.alu_a} - {8'h00, bus.alu_b})
                                 : ({8'h00, bus.alu_a} + {8'h00, bus.alu_b});
      3'd1: alu_res_q <= {8'h00, bus.alu_a} - {8'h00, bus.alu_b};
      3'd2: alu_res_q <= {8'h00, bus.alu_a};
      3'd3: alu_res_q <= {8'h00, bus.alu_b};
      3'd4: alu_res_q <= 16'h0000 - {8'h00, bus.alu_a};
      default: begin
        alu_res_q <= 16'h0000;
        if (reset_n === 1'b1) alu_saw_illegal <= 1'b1;
      end
    endcase
  end
  assign bus.alu_result   = alu_res_q;
  assign bus.alu_addr_out = bus.alu_addr ^ {7'b0, addr_corrupt};

  // Scoreboard state
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  int          obs_cyc_q[$];
  int          cyc = 0;
  int          n_acc = 0;
  int          n_cons = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Response = {result, tag, err}, straight from the arithmetic rules.
  function automatic logic [24:0] model_rsp(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic [7:0] tag,
                                            input logic corrupt);
    int unsigned ua, ub, r;
    ua = a;
    ub = b;
    case (op)
      3'd0:    r = ua + ub;
      3'd1:    r = ua - ub;
      3'd2:    r = ua;
      3'd3:    r = ub;
      3'd4:    r = 32'd0 - ua;
      default: r = 0;
    endcase
    if (op > 3'd4 || corrupt) return {16'h0000, tag, 1'b1};
    return {r[15:0], tag, 1'b0};
  endfunction

  // Records handshakes happening at the coming posedge, then advances one cycle.
  task automatic tick();
    if (bus.req_valid && bus.req_ready) begin
      exp_q.push_back(model_rsp(bus.req_a, bus.req_b, bus.req_opcode, bus.req_tag, addr_corrupt));
      n_acc++;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      obs_q.push_back({bus.rsp_result, bus.rsp_tag, bus.rsp_err});
      obs_cyc_q.push_back(cyc);
      n_cons++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
    n_acc  = 0;
    n_cons = 0;
  endtask

  task automatic set_req(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] tag);
    bus.req_valid  = v;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_opcode = op;
    bus.req_tag    = tag;
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while (n_cons < n_acc && k < max_cycles) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready);
    else n_pass++;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err} !== 26'h0)
      $display("FAIL reset_rsp got=%h exp=0", {bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err});
    else n_pass++;
    n_checks++;
    if ({bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_addr} !== {3'd2, 24'h0})
      $display("FAIL reset_alu_idle got=%h exp=%h", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_addr}, {3'd2, 24'h0});
    else n_pass++;
`ifdef ALU_REQ_DRIVER_CHECK_EN
    n_checks++;
    if ({chk_error, chk_count} !== 17'h0) $display("FAIL reset_chk got=%h exp=0", {chk_error, chk_count});
    else n_pass++;
`endif
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", bus.req_ready);
    else n_pass++;
    clear_sb();
  endtask

  task automatic test_add_latency();
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 8'hFF, 8'h01, 3'd0, 8'h11);
    tick();
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    n_checks++;
    if ({bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_addr} !== {3'd0, 8'hFF, 8'h01, 8'h11})
      $display("FAIL add_alu_pins got=%h exp=%h", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_addr}, {3'd0, 8'hFF, 8'h01, 8'h11});
    else n_pass++;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL add_rsp_early1 got=%b exp=0", bus.rsp_valid);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.rsp_valid, bus.alu_opcode} !== {1'b0, 3'd2}) $display("FAIL add_rsp_early2 got=%h exp=%h", {bus.rsp_valid, bus.alu_opcode}, {1'b0, 3'd2});
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err} !== {1'b1, 16'h0100, 8'h11, 1'b0})
      $display("FAIL add_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err}, {1'b1, 16'h0100, 8'h11, 1'b0});
    else n_pass++;
    tick();
    clear_sb();
  endtask

  task automatic test_back_to_back();
    logic [24:0] exp_c[3];
    logic [24:0] got;
    exp_c[0] = {16'hFFFE, 8'h01, 1'b0};
    exp_c[1] = {16'hFFFF, 8'h02, 1'b0};
    exp_c[2] = {16'h007E, 8'h03, 1'b0};
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 8'h03, 8'h05, 3'd1, 8'h01); tick();
    set_req(1'b1, 8'h01, 8'h00, 3'd4, 8'h02); tick();
    set_req(1'b1, 8'h00, 8'h7E, 3'd3, 8'h03); tick();
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    drain(12);
    for (int i = 0; i < 3; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 25'hx;
      n_checks++;
      if (got !== exp_c[i]) $display("FAIL b2b_rsp%0d got=%h exp=%h", i, got, exp_c[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_cyc_q.size() != 3 || obs_cyc_q[1] != obs_cyc_q[0] + 1 || obs_cyc_q[2] != obs_cyc_q[1] + 1)
      $display("FAIL b2b_consecutive got=%0d responses exp=3 on consecutive cycles", obs_cyc_q.size());
    else n_pass++;
    clear_sb();
  endtask

  task automatic test_backpressure();
    logic [24:0] got;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 8'(8'h10 + i), 8'h01, 3'd0, 8'(8'h40 + i));
      tick();
      if (i == 3) begin
        n_checks++;
        if (bus.req_ready !== 1'b0) $display("FAIL bp_ready_after4 got=%b exp=0", bus.req_ready);
        else n_pass++;
      end
    end
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    n_checks++;
    if (n_acc != 4) $display("FAIL bp_accepted got=%0d exp=4", n_acc);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    drain(20);
    n_checks++;
    if (obs_q.size() != 4) $display("FAIL bp_drain_count got=%0d exp=4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 25'hx;
      n_checks++;
      if (got !== exp_q[i]) $display("FAIL bp_rsp%0d got=%h exp=%h", i, got, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL bp_ready_return got=%b exp=1", bus.req_ready);
    else n_pass++;
    clear_sb();
  endtask

  task automatic test_illegal();
    logic [24:0] exp_c[3];
    logic [24:0] got;
    exp_c[0] = {16'h0003, 8'h21, 1'b0};
    exp_c[1] = {16'h0000, 8'h22, 1'b1};
    exp_c[2] = {16'h0005, 8'h23, 1'b0};
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 8'h01, 8'h02, 3'd0, 8'h21); tick();
    set_req(1'b1, 8'h55, 8'h66, 3'd6, 8'h22); tick();
    n_checks++;
    if ({bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_addr} !== {3'd2, 24'h0})
      $display("FAIL illegal_alu_idle got=%h exp=%h", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_addr}, {3'd2, 24'h0});
    else n_pass++;
    set_req(1'b1, 8'h09, 8'h04, 3'd1, 8'h23); tick();
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    drain(12);
    for (int i = 0; i < 3; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 25'hx;
      n_checks++;
      if (got !== exp_c[i]) $display("FAIL illegal_rsp%0d got=%h exp=%h", i, got, exp_c[i]);
      else n_pass++;
    end
    clear_sb();
  endtask

  task automatic test_addr_check();
    logic [24:0] got;
    bus.rsp_ready = 1'b1;
    addr_corrupt  = 1'b1;
    set_req(1'b1, 8'h44, 8'h00, 3'd2, 8'h44); tick();
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    drain(10);
    addr_corrupt = 1'b0;
    got = (obs_q.size() > 0) ? obs_q[0] : 25'hx;
    n_checks++;
    if (got !== {16'h0000, 8'h44, 1'b1}) $display("FAIL addr_mismatch got=%h exp=%h", got, {16'h0000, 8'h44, 1'b1});
    else n_pass++;
    clear_sb();
  endtask

  task automatic test_reset_midflight();
    logic [24:0] got;
    bus.rsp_ready = 1'b0;
    set_req(1'b1, 8'h01, 8'h01, 3'd0, 8'h61); tick();
    set_req(1'b1, 8'h02, 8'h02, 3'd0, 8'h62); tick();
    set_req(1'b1, 8'h03, 8'h03, 3'd0, 8'h63); tick();
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b00) $display("FAIL midrst_outputs got=%b exp=00", {bus.rsp_valid, bus.req_ready});
    else n_pass++;
    reset_n = 1'b1;
    clear_sb();
    bus.rsp_ready = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (n_cons != 0) $display("FAIL midrst_stale got=%0d responses exp=0", n_cons);
    else n_pass++;
    set_req(1'b1, 8'h02, 8'h03, 3'd0, 8'h33); tick();
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    drain(10);
    got = (obs_q.size() > 0) ? obs_q[0] : 25'hx;
    n_checks++;
    if (got !== {16'h0005, 8'h33, 1'b0}) $display("FAIL midrst_new_add got=%h exp=%h", got, {16'h0005, 8'h33, 1'b0});
    else n_pass++;
    clear_sb();
  endtask

  task automatic test_random();
    logic        hold;
    logic [24:0] held;
    logic [24:0] got;
    logic        exp_ready;
    int          bad_ready, bad_hold;
    bad_ready = 0;
    bad_hold  = 0;
    hold      = 1'b0;
    held      = '0;
    for (int c = 0; c < 600; c++) begin
      exp_ready = ((n_acc - n_cons) < DEPTH);
      if (bus.req_ready !== exp_ready) bad_ready++;
      if (hold && {bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err} !== {1'b1, held}) bad_hold++;
      set_req(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom));
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
      hold = bus.rsp_valid && !bus.rsp_ready;
      held = {bus.rsp_result, bus.rsp_tag, bus.rsp_err};
      tick();
    end
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    bus.rsp_ready = 1'b1;
    drain(40);
    n_checks++;
    if (bad_ready != 0) $display("FAIL rand_req_ready got=%0d wrong cycles exp=0", bad_ready);
    else n_pass++;
    n_checks++;
    if (bad_hold != 0) $display("FAIL rand_rsp_stable got=%0d unstable cycles exp=0", bad_hold);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() < 50)
      $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 25'hx;
      n_checks++;
      if (got !== exp_q[i]) $display("FAIL rand_rsp%0d got=%h exp=%h", i, got, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (alu_saw_illegal !== 1'b0) $display("FAIL alu_illegal_opcode got=%b exp=0", alu_saw_illegal);
    else n_pass++;
    clear_sb();
  endtask

`ifdef ALU_REQ_DRIVER_CHECK_EN
  task automatic test_checker();
    logic [24:0] got;
    bus.rsp_ready = 1'b1;
    bad_add       = 1'b1;
    set_req(1'b1, 8'h05, 8'h03, 3'd0, 8'h55); tick();
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    drain(10);
    got = (obs_q.size() > 0) ? obs_q[0] : 25'hx;
    n_checks++;
    if (got !== {16'h0002, 8'h55, 1'b0}) $display("FAIL chk_rsp got=%h exp=%h", got, {16'h0002, 8'h55, 1'b0});
    else n_pass++;
    n_checks++;
    if ({chk_error, chk_count} !== {1'b1, 16'd1}) $display("FAIL chk_first got=%h exp=%h", {chk_error, chk_count}, {1'b1, 16'd1});
    else n_pass++;
    set_req(1'b1, 8'h07, 8'h00, 3'd2, 8'h56); tick();
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    drain(10);
    tick();
    n_checks++;
    if ({chk_error, chk_count} !== {1'b1, 16'd1}) $display("FAIL chk_passa got=%h exp=%h", {chk_error, chk_count}, {1'b1, 16'd1});
    else n_pass++;
    bad_add = 1'b0;
    clear_sb();
  endtask
`endif

  initial begin
    reset_n       = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 8'h0, 8'h0, 3'd0, 8'h0);
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_addr_check();
    test_reset_midflight();
    test_random();
`ifdef ALU_REQ_DRIVER_CHECK_EN
    test_checker();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
